// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: drives kin/ce through start->stop(->start).
// Optional DDS_SWEEP_LOOP_EN adds cfg_loop for continuous repeat.
module dds_sweep_ctrl #(
  parameter int KW  = 4,
  parameter int DWW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           abort,
  input  logic [KW-1:0]  cfg_start_k,
  input  logic [KW-1:0]  cfg_stop_k,
  input  logic [KW-1:0]  cfg_step,
  input  logic [DWW-1:0] cfg_dwell,
  input  logic           cfg_pingpong,
`ifdef DDS_SWEEP_LOOP_EN
  input  logic           cfg_loop,
`endif
  output logic           dds_ce,
  output logic [KW-1:0]  dds_kin,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  cur_k_q, cur_k_d;
  logic [KW-1:0]  tgt_q, tgt_d;
  logic           dir_up_q, dir_up_d;
  logic           phase2_q, phase2_d;
  logic [DWW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWW-1:0] dwell_rl_q, dwell_rl_d;
  logic [KW-1:0]  step_q, step_d;
  logic [KW-1:0]  start_k_q, start_k_d;
  logic           pp_q, pp_d;
  logic           loop_req;

`ifdef DDS_SWEEP_LOOP_EN
  assign loop_req = cfg_loop;
`else
  assign loop_req = 1'b0;
`endif

  // One step toward tgt in KW+1 bits, clamped so it never passes tgt.
  function automatic logic [KW-1:0] step_toward(
    input logic [KW-1:0] cur,
    input logic [KW-1:0] tgt,
    input logic [KW-1:0] stp,
    input logic          up
  );
    logic [KW:0] s;
    logic [KW-1:0] r;
    if (up) begin
      s = {1'b0, cur} + {1'b0, stp};
      r = (s > {1'b0, tgt}) ? tgt : s[KW-1:0];
    end else begin
      s = {1'b0, cur} - {1'b0, stp};
      r = (s[KW] || (s[KW-1:0] < tgt)) ? tgt : s[KW-1:0];
    end
    return r;
  endfunction

  logic at_end;
  logic can_turn;

  assign at_end   = (cur_k_q == tgt_q) || (step_q == '0);
  assign can_turn = pp_q && !phase2_q && (step_q != '0) &&
                    (start_k_q != tgt_q);

  always_comb begin
    state_d     = state_q;
    cur_k_d     = cur_k_q;
    tgt_d       = tgt_q;
    dir_up_d    = dir_up_q;
    phase2_d    = phase2_q;
    dwell_cnt_d = dwell_cnt_q;
    dwell_rl_d  = dwell_rl_q;
    step_d      = step_q;
    start_k_d   = start_k_q;
    pp_d        = pp_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) state_d = S_LOAD;
      end
      S_LOAD: begin
        cur_k_d     = cfg_start_k;
        tgt_d       = cfg_stop_k;
        dir_up_d    = (cfg_stop_k >= cfg_start_k);
        phase2_d    = 1'b0;
        dwell_cnt_d = cfg_dwell;
        dwell_rl_d  = cfg_dwell;
        step_d      = cfg_step;
        start_k_d   = cfg_start_k;
        pp_d        = cfg_pingpong;
        state_d     = S_DWELL;
      end
      S_DWELL: begin
        if (dwell_cnt_q != '0) begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end else if (at_end) begin
          if (can_turn) begin
            phase2_d    = 1'b1;
            tgt_d       = start_k_q;
            dir_up_d    = !dir_up_q;
            cur_k_d     = step_toward(cur_k_q, start_k_q,
                                      step_q, !dir_up_q);
            dwell_cnt_d = dwell_rl_q;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cur_k_d     = step_toward(cur_k_q, tgt_q, step_q, dir_up_q);
          dwell_cnt_d = dwell_rl_q;
        end
      end
      S_DONE: begin
        state_d = loop_req ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_k_q     <= '0;
      tgt_q       <= '0;
      dir_up_q    <= 1'b1;
      phase2_q    <= 1'b0;
      dwell_cnt_q <= '0;
      dwell_rl_q  <= '0;
      step_q      <= '0;
      start_k_q   <= '0;
      pp_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_k_q     <= cur_k_d;
      tgt_q       <= tgt_d;
      dir_up_q    <= dir_up_d;
      phase2_q    <= phase2_d;
      dwell_cnt_q <= dwell_cnt_d;
      dwell_rl_q  <= dwell_rl_d;
      step_q      <= step_d;
      start_k_q   <= start_k_d;
      pp_q        <= pp_d;
    end
  end

  // Outputs are pure decodes of flops; kin keeps the last word when idle.
  assign dds_ce  = (state_q == S_DWELL);
  assign dds_kin = cur_k_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: word-list model vs per-cycle output.
// Build with DDS_SWEEP_LOOP_EN to include the loop scenario.
module tb_dds_sweep_ctrl;
  localparam int KW  = 4;
  localparam int DWW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [KW-1:0]  cfg_start_k = '0;
  logic [KW-1:0]  cfg_stop_k = '0;
  logic [KW-1:0]  cfg_step = '0;
  logic [DWW-1:0] cfg_dwell = '0;
  logic           cfg_pingpong = 1'b0;
  logic           cfg_loop = 1'b0;
  logic           dds_ce;
  logic [KW-1:0]  dds_kin;
  logic           busy;
  logic           done;

  dds_sweep_ctrl #(.KW(KW), .DWW(DWW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .cfg_start_k(cfg_start_k),
    .cfg_stop_k(cfg_stop_k),
    .cfg_step(cfg_step),
    .cfg_dwell(cfg_dwell),
    .cfg_pingpong(cfg_pingpong),
`ifdef DDS_SWEEP_LOOP_EN
    .cfg_loop(cfg_loop),
`endif
    .dds_ce(dds_ce),
    .dds_kin(dds_kin),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_done;
    int       kin;
  } item_t;

  item_t sb[$];
  int    words[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Words visited from a to b, excluding a, never overshooting b.
  task automatic walk(int a, int b, int st);
    int k = a;
    while (k != b) begin
      if (b > a) k = (k + st > b) ? b : k + st;
      else       k = (k - st < b) ? b : k - st;
      words.push_back(k);
    end
  endtask

  task automatic model(int s, int e, int st, bit pp);
    words.delete();
    words.push_back(s);
    if (st != 0 && s != e) begin
      walk(s, e, st);
      if (pp) walk(e, s, st);
    end
  endtask

  task automatic push_exp(int dw, bit with_done);
    item_t it;
    foreach (words[i]) begin
      for (int r = 0; r <= dw; r++) begin
        it.is_done = 1'b0;
        it.kin = words[i];
        sb.push_back(it);
      end
    end
    if (with_done) begin
      it.is_done = 1'b1;
      it.kin = 0;
      sb.push_back(it);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (dds_ce || done)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_extra: got ce=%0d done=%0d kin=%0d want none",
                 dds_ce, done, dds_kin);
      end else begin
        item_t it;
        it = sb.pop_front();
        check("sb_done", {31'd0, done}, {31'd0, it.is_done});
        if (!it.is_done) check("sb_kin", {28'd0, dds_kin}, it.kin);
      end
    end
  end

  task automatic set_cfg(int s, int e, int st, int dw, bit pp);
    cfg_start_k  = KW'(s);
    cfg_stop_k   = KW'(e);
    cfg_step     = KW'(st);
    cfg_dwell    = DWW'(dw);
    cfg_pingpong = pp;
  endtask

  // Call just after a negedge; returns just after the busy-low negedge.
  task automatic run_sweep(int s, int e, int st, int dw, bit pp);
    int cyc = 0;
    bit got = 0;
    int last;
    set_cfg(s, e, st, dw, pp);
    model(s, e, st, pp);
    last = words[words.size()-1];
    push_exp(dw, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy_load", {31'd0, busy}, 1);
      if (cyc == 2) set_cfg($urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 15), $urandom_range(0, 3),
                            1'($urandom_range(0, 1)));
      if (done) got = 1;
    end
    check("done_cycle", cyc, 2 + words.size() * (dw + 1));
    @(negedge clk);
    check("busy_after", {31'd0, busy}, 0);
    check("ce_after", {31'd0, dds_ce}, 0);
    check("kin_hold", {28'd0, dds_kin}, last);
  endtask

  initial begin
    #3;
    check("rst_ce", {31'd0, dds_ce}, 0);
    check("rst_kin", {28'd0, dds_kin}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(2, 8, 3, 1, 0);
    run_sweep(1, 6, 4, 0, 0);
    run_sweep(9, 3, 2, 0, 0);
    run_sweep(2, 8, 3, 0, 1);
    run_sweep(4, 4, 0, 2, 1);
    run_sweep(5, 11, 0, 1, 1);
    run_sweep(0, 15, 15, 0, 1);
    run_sweep(15, 0, 7, 1, 1);
    for (int i = 0; i < 20; i++)
      run_sweep($urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));

    // start with abort in IDLE must not launch
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check("idle_start_abort", {31'd0, busy}, 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    // abort in the 3rd DWELL cycle; start while busy ignored
    set_cfg(0, 15, 1, 0, 0);
    model(0, 15, 1, 0);
    words = words[0:2];
    push_exp(0, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_ce", {31'd0, dds_ce}, 0);
    check("abort_done", {31'd0, done}, 0);
    abort = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_sb_empty", sb.size(), 0);
    check("abort_still_idle", {31'd0, busy}, 0);

    // asynchronous reset mid-sweep
    set_cfg(3, 14, 2, 1, 1);
    model(3, 14, 2, 1);
    push_exp(1, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ce", {31'd0, dds_ce}, 0);
    check("mrst_kin", {28'd0, dds_kin}, 0);
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_done", {31'd0, done}, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_idle", {31'd0, busy}, 0);

    run_sweep(6, 2, 1, 0, 1);

`ifdef DDS_SWEEP_LOOP_EN
    begin
      int ndone = 0;
      int cyc = 0;
      int last_done = 0;
      cfg_loop = 1'b1;
      set_cfg(0, 3, 3, 0, 0);
      model(0, 3, 3, 0);
      repeat (3) push_exp(0, 1'b1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (ndone < 3 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (done) begin
          ndone++;
          if (ndone == 1) check("loop_first", cyc, 4);
          else check("loop_period", cyc - last_done, 4);
          last_done = cyc;
          if (ndone == 3) abort = 1'b1;
        end
      end
      check("loop_passes", ndone, 3);
      @(negedge clk);
      abort = 1'b0;
      cfg_loop = 1'b0;
      check("loop_abort_busy", {31'd0, busy}, 0);
      repeat (3) @(negedge clk);
      check("loop_sb_empty", sb.size(), 0);
    end
`endif

    check("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS sine/cosine generator. It drives the generator's `kin` tuning word and `ce` enable through a programmed sweep: start word, stop word, step size, and dwell time per step, with optional ping-pong return. The host starts and stops it through a start/abort/busy/done handshake. It sits between the register/host interface and `dds_sincos_gen`.

## Interface
- `KW`, 4: tuning-word width; must match the DDS `kin` width.
- `DWW`, 16: dwell counter width.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  sweep request, sampled in IDLE only.
- `abort`  in  1  terminate sweep; has priority over `start`.
- `cfg_start_k`  in  KW  first tuning word.
- `cfg_stop_k`  in  KW  final tuning word; may be below `cfg_start_k` (down-sweep).
- `cfg_step`  in  KW  step magnitude.
- `cfg_dwell`  in  DWW  each word is held for `cfg_dwell+1` enabled cycles.
- `cfg_pingpong`  in  1  after reaching stop, sweep back to start.
- `cfg_loop`  in  1  present only with `DDS_SWEEP_LOOP_EN`.
- `dds_ce`  out  1  to DDS `ce`.
- `dds_kin`  out  KW  to DDS `kin`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- **Shadow registers.** Config is latched into shadow registers in LOAD. Config changes during a sweep have no effect.
- **Registered outputs.** All outputs come from registered state. There is no combinational input-to-output path.
- **FSM states:** IDLE, LOAD, DWELL, DONE.
- **IDLE**
  - `dds_ce`=0, `dds_kin` holds its last value.
  - `start`=1 and `abort`=0 → LOAD.
- **LOAD** (1 cycle)
  - `cur_k` ← `cfg_start_k`; `tgt` ← `cfg_stop_k`.
  - `dir_up` ← (`cfg_stop_k` ≥ `cfg_start_k`); `phase2` ← 0; `dwell_cnt` ← `cfg_dwell`.
  - → DWELL.
- **DWELL**
  - `dds_ce`=1, `dds_kin`=`cur_k`; `dwell_cnt` decrements each cycle.
  - When `dwell_cnt`==0, exactly one of the following applies:
    - `cur_k`==`tgt` or step==0:
      - if pingpong, phase2==0 and step≠0 and start≠stop: `phase2` ← 1, `tgt` ← start, `dir_up` inverted, `cur_k` steps toward the new target.
      - otherwise → DONE.
    - else: `cur_k` ← `cur_k` ± step, computed in KW+1 bits and clamped to `tgt` if it would pass it. `dwell_cnt` reloads. State stays DWELL.
  - Word transitions are back-to-back. `dds_ce` never drops between words, so DDS phase stays continuous.
- **DONE** (1 cycle)
  - `done`=1, `dds_ce`=0 → IDLE.
  - With the loop feature enabled (see Configuration), → LOAD instead.
- **abort**
  - In any non-IDLE state → IDLE on the next edge. `done` is not pulsed.
  - `dds_ce` is 0 from the following cycle.
- **start while busy:** ignored.
- **Reset:** `dds_ce`=0, `dds_kin`=0, `busy`=0, `done`=0, state IDLE.
  - Reset mid-sweep returns everything to these values immediately (asynchronous).

## Timing
- `start` sampled at edge n → LOAD in cycle n+1, first `dds_ce`=1 in cycle n+2.
- Number of words in a sweep: N. Words visited go start→stop; with pingpong, back to start.
- `done` occurs in cycle n+2+N·(`cfg_dwell`+1). `busy` falls in the cycle after `done`.
- Earliest re-start: `start` sampled in the cycle after `done`.
- `abort` sampled at edge m → `busy`=0 and `dds_ce`=0 in cycle m+1.
- Simultaneous `start` and `abort` in IDLE: stays in IDLE.

## Configuration
- `DDS_SWEEP_LOOP_EN` defined:
  - `cfg_loop` port exists.
  - If `cfg_loop`=1 when DONE is reached, DONE → LOAD. `done` still pulses once per pass.
  - Config is re-latched in LOAD, and the sweep repeats until `abort`.
- Undefined: no `cfg_loop` port; DONE always → IDLE.

## Test plan
- Up-sweep: start=2, stop=8, step=3, dwell=1 → `dds_kin` 2,2,5,5,8,8 with `dds_ce`=1 for 6 cycles; `done` at n+8; `busy` low at n+9.
- Clamp and down-sweep:
  - start=1, stop=6, step=4, dwell=0 → 1,5,6.
  - start=9, stop=3, step=2, dwell=0 → 9,7,5,3.
- Ping-pong: start=2, stop=8, step=3, dwell=0, pingpong=1 → 2,5,8,5,2, then `done`.
- Step=0 or start==stop: start=4, stop=4, step=0, dwell=2 → three cycles of `kin`=4, then `done`; no reversal even with pingpong=1.
- Abort and reset:
  - `abort` in the 3rd DWELL cycle → `dds_ce`=0 and `busy`=0 next cycle, no `done`; `start` during the sweep is ignored.
  - `rst_n` low mid-sweep → all outputs 0 immediately.
- Loop (macro defined): `cfg_loop`=1, start=0, stop=3, step=3, dwell=0 → 0,3, gap of 2 cycles (DONE, LOAD), 0,3, …; `done` pulses each pass; stops on `abort`.
